ps2_keycode_capture: RTL and testbench

- Front end of the keyboard path: deserializes device-to-host PS/2 frames from the keyboard pins into bytes.
- Maintains a 32-bit scan-code history word `keycode`. Newest byte sits in [7:0]; older bytes shift toward [31:24].
- Downstream digit/break decoding consumes `keycode` directly. Break detection tests keycode[15:8] == 8'hF0.
- Also reports per-byte completion and framing errors.

---
 rtl/ps2_keycode_capture.sv | 149 ++++++++++++++
 tb/tb_ps2_keycode_capture.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_capture.sv
// ps2_keycode_capture: PS/2 device-to-host deserializer with a 32-bit scan-code history and error pulses.
// Optional macro PS2_KEYCODE_BREAK_EN adds the key_release output.
`default_nettype none

module ps2_keycode_capture #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keycode,
  output logic        byte_valid,
  output logic        frame_err
`ifdef PS2_KEYCODE_BREAK_EN
  ,
  output logic        key_release
`endif
);

  localparam int RUN_W = 4;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic             clk_s1_q, clk_s2_q;
  logic             dat_s1_q, dat_s2_q;
  logic             filt_q, filt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             fall_q;

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [TO_W-1:0]  to_q;

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (clk_s2_q != filt_q) begin
      if (run_q == RUN_W'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      run_q    <= '0;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      run_q    <= run_d;
      fall_q   <= filt_q & ~filt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_q        <= '0;
      keycode     <= '0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_KEYCODE_BREAK_EN
      key_release <= 1'b0;
`endif
    end else begin
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_KEYCODE_BREAK_EN
      key_release <= 1'b0;
`endif
      if (state_q == IDLE || fall_q) begin
        to_q <= '0;
      end else if (to_q != '1) begin
        to_q <= to_q + 1'b1;
      end

      // Timeout wins over a coincident fall event; that edge is dropped.
      if (state_q != IDLE && to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        frame_err <= 1'b1;
      end else if (fall_q) begin
        case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift_q <= {dat_s2_q, shift_q[7:1]};
            if (cnt_q == 3'd7) begin
              state_q <= PARITY;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            if (dat_s2_q && (^{shift_q, par_q})) begin
              keycode    <= {keycode[23:0], shift_q};
              byte_valid <= 1'b1;
`ifdef PS2_KEYCODE_BREAK_EN
              key_release <= (shift_q != 8'hF0) && (keycode[7:0] == 8'hF0);
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_keycode_capture.sv
// Self-checking bench for ps2_keycode_capture: randomized frames against a byte-history reference model.
`default_nettype none

module tb_ps2_keycode_capture;

  localparam int FLT = 4;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keycode;
  logic        byte_valid;
  logic        frame_err;
`ifdef PS2_KEYCODE_BREAK_EN
  logic        key_release;
`else
  logic        key_release = 1'b0;
`endif

  ps2_keycode_capture #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keycode    (keycode),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
`ifdef PS2_KEYCODE_BREAK_EN
    ,
    .key_release(key_release)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor: pulse counters and anomaly counters sampled away from the active edge.
  int          bv_cnt = 0, fe_cnt = 0, kr_cnt = 0;
  int          both_cnt = 0, stray_cnt = 0;
  logic [31:0] last_kc = '0;
  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_release) kr_cnt++;
    if (byte_valid && frame_err) both_cnt++;
    if (!reset && !byte_valid && (keycode != last_kc || key_release)) stray_cnt++;
    last_kc = keycode;
  end

  // Reference model: history of accepted bytes.
  logic [31:0] m_kc = '0;
  int          m_kr = 0;

  task automatic model_accept(input logic [7:0] b);
    if (b != 8'hF0 && m_kc[7:0] == 8'hF0) m_kr++;
    m_kc = {m_kc[23:0], b};
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);
    m_kc = '0;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(4); ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1; wait_cyc(4);
    end else begin
      wait_cyc(10);
    end
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(3); ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1; wait_cyc(5);
    end else begin
      wait_cyc(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop_b, input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit((~^b) ^ par_bad, glitch);
    ps2_bit(stop_b, glitch);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (keycode !== 32'h0) begin failures++; $display("FAIL reset_keycode got=%h want=%h", keycode, 32'h0); end
    checks++;
    if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%b want=0", byte_valid); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
  endtask

  task automatic test_single();
    int bv0, fe0;
    bv0 = bv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    model_accept(8'h1C);
    checks++;
    if (bv_cnt - bv0 !== 1) begin failures++; $display("FAIL single_bv got=%0d want=1", bv_cnt - bv0); end
    checks++;
    if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL single_fe got=%0d want=0", fe_cnt - fe0); end
    checks++;
    if (keycode !== 32'h0000001C) begin failures++; $display("FAIL single_kc got=%h want=%h", keycode, 32'h1C); end
  endtask

  task automatic test_break_seq();
    int bv0, kr0, mkr0;
    logic [7:0] seq [3];
    seq = '{8'h1C, 8'hF0, 8'h1C};
    apply_reset();
    bv0 = bv_cnt; kr0 = kr_cnt; mkr0 = m_kr;
    for (int i = 0; i < 3; i++) begin
      send_frame(seq[i], 1'b0, 1'b1, 1'b0);
      model_accept(seq[i]);
    end
    checks++;
    if (bv_cnt - bv0 !== 3) begin failures++; $display("FAIL break_bv got=%0d want=3", bv_cnt - bv0); end
    checks++;
    if (keycode !== 32'h001CF01C || keycode !== m_kc) begin
      failures++; $display("FAIL break_kc got=%h want=%h", keycode, 32'h001CF01C);
    end
`ifdef PS2_KEYCODE_BREAK_EN
    checks++;
    if (kr_cnt - kr0 !== m_kr - mkr0 || m_kr - mkr0 != 1) begin
      failures++; $display("FAIL break_release got=%0d want=1", kr_cnt - kr0);
    end
`else
    checks++;
    if (kr_cnt - kr0 !== 0) begin failures++; $display("FAIL break_release got=%0d want=0", kr_cnt - kr0); end
`endif
  endtask

  task automatic test_parity();
    int bv0, fe0;
    logic [31:0] kc_before;
    kc_before = m_kc;
    bv0 = bv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    checks++;
    if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL parity_fe got=%0d want=1", fe_cnt - fe0); end
    checks++;
    if (bv_cnt - bv0 !== 0) begin failures++; $display("FAIL parity_bv got=%0d want=0", bv_cnt - bv0); end
    checks++;
    if (keycode !== kc_before) begin failures++; $display("FAIL parity_kc got=%h want=%h", keycode, kc_before); end
    send_frame(8'h45, 1'b0, 1'b1, 1'b0);
    model_accept(8'h45);
    checks++;
    if (keycode !== m_kc || bv_cnt - bv0 !== 1) begin
      failures++; $display("FAIL parity_recover got=%h want=%h", keycode, m_kc);
    end
  endtask

  task automatic test_timeout();
    int bv0, fe0, n;
    bit seen;
    logic [7:0] b;
    b = 8'($urandom);
    bv0 = bv_cnt; fe0 = fe_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0);
    ps2_data = b[4];
    wait_cyc(10);
    ps2_clk = 1'b0;
    seen = 1'b0;
    n = 0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      wait_cyc(1);
      n = c;
      if (c == 20) ps2_clk = 1'b1;
      if (frame_err) seen = 1'b1;
    end
    if (!seen) ps2_clk = 1'b1;
    checks++;
    if (!seen || n < TMO - 1 + FLT || n > TMO - 1 + FLT + 6) begin
      failures++; $display("FAIL timeout_latency got=%0d seen=%0b want=%0d..%0d", n, seen, TMO - 1 + FLT, TMO + FLT + 5);
    end
    ps2_data = 1'b1;
    wait_cyc(20);
    checks++;
    if (fe_cnt - fe0 !== 1 || bv_cnt - bv0 !== 0) begin
      failures++; $display("FAIL timeout_pulses got=fe%0d/bv%0d want=fe1/bv0", fe_cnt - fe0, bv_cnt - bv0);
    end
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    model_accept(8'h29);
    checks++;
    if (keycode !== m_kc || bv_cnt - bv0 !== 1 || fe_cnt - fe0 !== 1) begin
      failures++; $display("FAIL timeout_recover got=%h want=%h", keycode, m_kc);
    end
  endtask

  task automatic test_glitch();
    int bv0, fe0;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      bv0 = bv_cnt; fe0 = fe_cnt;
      send_frame(b, 1'b0, 1'b1, 1'b1);
      model_accept(b);
      checks++;
      if (keycode !== m_kc || bv_cnt - bv0 !== 1 || fe_cnt - fe0 !== 0) begin
        failures++; $display("FAIL glitch_frame got=%h want=%h bv=%0d fe=%0d", keycode, m_kc, bv_cnt - bv0, fe_cnt - fe0);
      end
    end
  endtask

  task automatic test_mid_reset();
    int bv0, fe0;
    bv0 = bv_cnt; fe0 = fe_cnt;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom), 1'b0);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    m_kc = '0;
    ps2_data = 1'b1;
    wait_cyc(10);
    checks++;
    if (bv_cnt - bv0 !== 0 || fe_cnt - fe0 !== 0) begin
      failures++; $display("FAIL midreset_pulses got=bv%0d/fe%0d want=0/0", bv_cnt - bv0, fe_cnt - fe0);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    model_accept(8'h5A);
    checks++;
    if (keycode !== 32'h0000005A) begin failures++; $display("FAIL midreset_kc got=%h want=%h", keycode, 32'h5A); end
  endtask

  task automatic test_random();
    int bv0, fe0, kr0, mkr0, kind, exp_bv, exp_fe;
    logic [7:0] b;
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 9);
      b = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
      bv0 = bv_cnt; fe0 = fe_cnt; kr0 = kr_cnt; mkr0 = m_kr;
      exp_bv = 0; exp_fe = 1;
      if (kind <= 5) begin
        send_frame(b, 1'b0, 1'b1, 1'b0);
        model_accept(b);
        exp_bv = 1; exp_fe = 0;
      end else if (kind == 6 || kind == 7) begin
        send_frame(b, 1'b1, 1'b1, 1'b0);
      end else if (kind == 8) begin
        send_frame(b, 1'b0, 1'b0, 1'b0);
      end else begin
        ps2_bit(1'b1, 1'b0);
        wait_cyc(20);
      end
      checks++;
      if (bv_cnt - bv0 !== exp_bv || fe_cnt - fe0 !== exp_fe) begin
        failures++; $display("FAIL rand_pulses kind=%0d got=bv%0d/fe%0d want=bv%0d/fe%0d", kind, bv_cnt - bv0, fe_cnt - fe0, exp_bv, exp_fe);
      end
      checks++;
      if (keycode !== m_kc) begin failures++; $display("FAIL rand_kc kind=%0d got=%h want=%h", kind, keycode, m_kc); end
`ifdef PS2_KEYCODE_BREAK_EN
      checks++;
      if (kr_cnt - kr0 !== m_kr - mkr0) begin
        failures++; $display("FAIL rand_release got=%0d want=%0d", kr_cnt - kr0, m_kr - mkr0);
      end
`endif
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (both_cnt !== 0) begin failures++; $display("FAIL overlap_pulses got=%0d want=0", both_cnt); end
    checks++;
    if (stray_cnt !== 0) begin failures++; $display("FAIL stray_update got=%0d want=0", stray_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_break_seq();
    test_parity();
    test_timeout();
    test_glitch();
    test_mid_reset();
    test_random();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
